// File: rtl/scratchpad_pkg.sv
// Shared types and width helpers for the result scratchpad bank.
// Default geometry lives here so sub-modules derive widths the same way.
package scratchpad_pkg;

    typedef enum logic [0:0] {
        SP_IDLE   = 1'b0,
        SP_STREAM = 1'b1
    } sp_state_e;

    function automatic int sp_clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int sp_elem_idx(input int row, input int col, input int max_dim);
        return row * max_dim + col;
    endfunction

    localparam int SP_DATA_WIDTH = 32;
    localparam int SP_MAX_DIM    = 4;
    localparam int SP_N_SLOTS    = 4;
    localparam int SP_SLOT_W     = sp_clog2_min1(SP_N_SLOTS);
    localparam int SP_ELEM_W     = sp_clog2_min1(SP_MAX_DIM * SP_MAX_DIM);
    localparam int SP_DIM_W      = $clog2(SP_MAX_DIM + 1);

endpackage

// File: rtl/sp_dump_ctrl.sv
// Row-major stream sequencer for one scratchpad slot, trimmed to the active dimension.
// state     | meaning
// SP_IDLE   | waiting for dump_start; rejects invalid slots via start_err_o
// SP_STREAM | presenting element (row_q, col_q); advances on ready
module sp_dump_ctrl
    import scratchpad_pkg::*;
#(
    parameter int MAX_DIM = SP_MAX_DIM,
    parameter int SLOT_W  = SP_SLOT_W,
    parameter int ELEM_W  = SP_ELEM_W,
    parameter int DIM_W   = SP_DIM_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [SLOT_W-1:0] start_slot_i,
    input  logic [DIM_W-1:0]  start_dim_i,
    input  logic              start_ok_i,
    input  logic              st_ready_i,
    output logic              busy_o,
    output logic              st_valid_o,
    output logic              st_last_o,
    output logic [SLOT_W-1:0] slot_o,
    output logic              load_o,
    output logic [SLOT_W-1:0] load_slot_o,
    output logic [ELEM_W-1:0] load_elem_o,
    output logic              start_err_o
);

    localparam logic [DIM_W-1:0] MAX_DIM_V = DIM_W'(MAX_DIM);

    sp_state_e         state_q, state_d;
    logic [DIM_W-1:0]  row_q, row_d, col_q, col_d, dim_q, dim_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [DIM_W-1:0]  dim_eff, last_idx;
    logic              is_last;

    assign dim_eff  = ((start_dim_i == '0) || (start_dim_i > MAX_DIM_V)) ? MAX_DIM_V : start_dim_i;
    assign last_idx = dim_q - DIM_W'(1);
    assign is_last  = (state_q == SP_STREAM) && (row_q == last_idx) && (col_q == last_idx);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SP_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            dim_q   <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            dim_q   <= dim_d;
            slot_q  <= slot_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        dim_d       = dim_q;
        slot_d      = slot_q;
        load_o      = 1'b0;
        load_slot_o = slot_q;
        load_elem_o = '0;
        start_err_o = 1'b0;
        case (state_q)
            SP_IDLE: begin
                if (start_i) begin
                    if (start_ok_i) begin
                        state_d     = SP_STREAM;
                        slot_d      = start_slot_i;
                        dim_d       = dim_eff;
                        row_d       = '0;
                        col_d       = '0;
                        load_o      = 1'b1;
                        load_slot_o = start_slot_i;
                    end else begin
                        start_err_o = 1'b1;
                    end
                end
            end
            SP_STREAM: begin
                if (st_ready_i) begin
                    if (is_last) begin
                        state_d = SP_IDLE;
                    end else begin
                        if (col_q == last_idx) begin
                            col_d = '0;
                            row_d = row_q + DIM_W'(1);
                        end else begin
                            col_d = col_q + DIM_W'(1);
                        end
                        // Prefetch the next element so st_data_o stays a plain register.
                        load_o      = 1'b1;
                        load_elem_o = ELEM_W'(sp_elem_idx(32'(row_d), 32'(col_d), MAX_DIM));
                    end
                end
            end
            default: state_d = SP_IDLE;
        endcase
    end

    assign busy_o     = (state_q == SP_STREAM);
    assign st_valid_o = (state_q == SP_STREAM);
    assign st_last_o  = is_last;
    assign slot_o     = slot_q;

endmodule

// File: rtl/result_scratchpad_bank.sv
// Multi-slot store for matrix-multiply results: single-cycle capture, random read,
// and a trimmed row-major stream dump of one slot.
module result_scratchpad_bank
    import scratchpad_pkg::*;
#(
    parameter int DATA_WIDTH = SP_DATA_WIDTH,
    parameter int MAX_DIM    = SP_MAX_DIM,
    parameter int N_SLOTS    = SP_N_SLOTS,
    parameter int SLOT_W     = sp_clog2_min1(N_SLOTS),
    parameter int ELEM_W     = sp_clog2_min1(MAX_DIM * MAX_DIM),
    parameter int DIM_W      = $clog2(MAX_DIM + 1)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  done_i,
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] res_flat_i,
    input  logic [SLOT_W-1:0]                     wr_slot_i,
    input  logic                                  clr_i,
    input  logic [SLOT_W-1:0]                     clr_slot_i,
    input  logic                                  rd_en_i,
    input  logic [SLOT_W-1:0]                     rd_slot_i,
    input  logic [ELEM_W-1:0]                     rd_elem_i,
    output logic [DATA_WIDTH-1:0]                 rd_data_o,
    output logic                                  rd_valid_o,
    input  logic                                  dump_start_i,
    input  logic [SLOT_W-1:0]                     dump_slot_i,
    input  logic [DIM_W-1:0]                      dump_dim_i,
    output logic                                  st_valid_o,
    output logic [DATA_WIDTH-1:0]                 st_data_o,
    output logic                                  st_last_o,
    input  logic                                  st_ready_i,
    output logic                                  busy_o,
    output logic [N_SLOTS-1:0]                    slot_valid_o,
    output logic                                  cap_err_o
);

    localparam int NUM_ELEM = MAX_DIM * MAX_DIM;

    logic [DATA_WIDTH-1:0] mem_q [N_SLOTS][NUM_ELEM];
    logic [N_SLOTS-1:0]    slot_valid_q;
    logic                  cap_ok, cap_rej, start_ok, start_err, rd_ok, load;
    logic [SLOT_W-1:0]     dump_slot, load_slot;
    logic [ELEM_W-1:0]     load_elem;

    // The slot under dump is write-protected so the streamed data cannot tear.
    assign cap_ok   = done_i && (32'(wr_slot_i) < N_SLOTS) && !(busy_o && (wr_slot_i == dump_slot));
    assign cap_rej  = done_i && !cap_ok;
    assign start_ok = (32'(dump_slot_i) < N_SLOTS) && slot_valid_q[dump_slot_i];
    assign rd_ok    = (32'(rd_slot_i) < N_SLOTS) && (32'(rd_elem_i) < NUM_ELEM);

    sp_dump_ctrl #(
        .MAX_DIM (MAX_DIM),
        .SLOT_W  (SLOT_W),
        .ELEM_W  (ELEM_W),
        .DIM_W   (DIM_W)
    ) u_dump_ctrl (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (dump_start_i),
        .start_slot_i (dump_slot_i),
        .start_dim_i  (dump_dim_i),
        .start_ok_i   (start_ok),
        .st_ready_i   (st_ready_i),
        .busy_o       (busy_o),
        .st_valid_o   (st_valid_o),
        .st_last_o    (st_last_o),
        .slot_o       (dump_slot),
        .load_o       (load),
        .load_slot_o  (load_slot),
        .load_elem_o  (load_elem),
        .start_err_o  (start_err)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < N_SLOTS; s++) begin
                for (int e = 0; e < NUM_ELEM; e++) begin
                    mem_q[s][e] <= '0;
                end
            end
        end else if (cap_ok) begin
            for (int e = 0; e < NUM_ELEM; e++) begin
                mem_q[wr_slot_i][e] <= res_flat_i[e*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Capture beats clear when both hit the same slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid_q <= '0;
        end else begin
            for (int s = 0; s < N_SLOTS; s++) begin
                if (cap_ok && (wr_slot_i == SLOT_W'(s))) begin
                    slot_valid_q[s] <= 1'b1;
                end else if (clr_i && (clr_slot_i == SLOT_W'(s))) begin
                    slot_valid_q[s] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
            st_data_o  <= '0;
            cap_err_o  <= 1'b0;
        end else begin
            rd_valid_o <= rd_en_i;
            if (rd_en_i) begin
                rd_data_o <= rd_ok ? mem_q[rd_slot_i][rd_elem_i] : '0;
            end
            if (load) begin
                st_data_o <= mem_q[load_slot][load_elem];
            end
            cap_err_o <= cap_rej || start_err;
        end
    end

    assign slot_valid_o = slot_valid_q;

endmodule

// File: tb/tb_result_scratchpad_bank.sv
// Directed bench for result_scratchpad_bank: capture, read, stream dump with stalls,
// write protection during dump, invalid-slot dump and clear/capture priority.
module tb_result_scratchpad_bank;

    localparam int DW = 32;
    localparam int MD = 4;
    localparam int NS = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              done_i;
    logic [MD*MD*DW-1:0] res_flat_i;
    logic [1:0]        wr_slot_i;
    logic              clr_i;
    logic [1:0]        clr_slot_i;
    logic              rd_en_i;
    logic [1:0]        rd_slot_i;
    logic [3:0]        rd_elem_i;
    logic [DW-1:0]     rd_data_o;
    logic              rd_valid_o;
    logic              dump_start_i;
    logic [1:0]        dump_slot_i;
    logic [2:0]        dump_dim_i;
    logic              st_valid_o;
    logic [DW-1:0]     st_data_o;
    logic              st_last_o;
    logic              st_ready_i;
    logic              busy_o;
    logic [NS-1:0]     slot_valid_o;
    logic              cap_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] exp_beats [9] = '{32'h100, 32'h101, 32'h102, 32'h104, 32'h105,
                                     32'h106, 32'h108, 32'h109, 32'h10A};

    result_scratchpad_bank dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .done_i       (done_i),
        .res_flat_i   (res_flat_i),
        .wr_slot_i    (wr_slot_i),
        .clr_i        (clr_i),
        .clr_slot_i   (clr_slot_i),
        .rd_en_i      (rd_en_i),
        .rd_slot_i    (rd_slot_i),
        .rd_elem_i    (rd_elem_i),
        .rd_data_o    (rd_data_o),
        .rd_valid_o   (rd_valid_o),
        .dump_start_i (dump_start_i),
        .dump_slot_i  (dump_slot_i),
        .dump_dim_i   (dump_dim_i),
        .st_valid_o   (st_valid_o),
        .st_data_o    (st_data_o),
        .st_last_o    (st_last_o),
        .st_ready_i   (st_ready_i),
        .busy_o       (busy_o),
        .slot_valid_o (slot_valid_o),
        .cap_err_o    (cap_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic fill_res(input logic [31:0] base);
        for (int k = 0; k < MD*MD; k++) res_flat_i[k*DW +: DW] = base + 32'(k);
    endtask

    initial begin
        rst_ni = 1'b0;
        done_i = 0; res_flat_i = '0; wr_slot_i = 0; clr_i = 0; clr_slot_i = 0;
        rd_en_i = 0; rd_slot_i = 0; rd_elem_i = 0;
        dump_start_i = 0; dump_slot_i = 0; dump_dim_i = 0; st_ready_i = 1;
        #22;
        check("rst_slot_valid", 32'(slot_valid_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        check("rst_st_valid", 32'(st_valid_o), 32'h0);
        check("rst_rd_valid", 32'(rd_valid_o), 32'h0);
        check("rst_cap_err", 32'(cap_err_o), 32'h0);
        rst_ni = 1'b1;
        tick();

        // Read of empty storage
        rd_en_i = 1; rd_slot_i = 0; rd_elem_i = 5;
        tick();
        rd_en_i = 0;
        check("rd0_valid", 32'(rd_valid_o), 32'h1);
        check("rd0_data", rd_data_o, 32'h0);
        tick();
        check("rd0_valid_drop", 32'(rd_valid_o), 32'h0);

        // Capture into slot 2
        fill_res(32'h100);
        done_i = 1; wr_slot_i = 2;
        tick();
        done_i = 0;
        check("cap_slot_valid", 32'(slot_valid_o), 32'h4);
        check("cap_no_err", 32'(cap_err_o), 32'h0);
        rd_en_i = 1; rd_slot_i = 2; rd_elem_i = 15;
        tick();
        rd_en_i = 0;
        check("rd_2_15", rd_data_o, 32'h10F);

        // Dump slot 2, dim 3, ready held high
        dump_start_i = 1; dump_slot_i = 2; dump_dim_i = 3; st_ready_i = 1;
        tick();
        dump_start_i = 0;
        check("dump1_busy", 32'(busy_o), 32'h1);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("dump1_valid_%0d", i), 32'(st_valid_o), 32'h1);
            check($sformatf("dump1_data_%0d", i), st_data_o, exp_beats[i]);
            check($sformatf("dump1_last_%0d", i), 32'(st_last_o), (i == 8) ? 32'h1 : 32'h0);
            tick();
        end
        check("dump1_busy_low", 32'(busy_o), 32'h0);
        check("dump1_valid_low", 32'(st_valid_o), 32'h0);

        // Same dump with a 3-cycle stall at beat 4, captures during the stall
        dump_start_i = 1; dump_slot_i = 2; dump_dim_i = 3;
        tick();
        dump_start_i = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 4) begin
                st_ready_i = 0;
                fill_res(32'h200);
                done_i = 1; wr_slot_i = 2;
                tick();
                done_i = 0;
                check("stall1_data", st_data_o, 32'h105);
                check("cap_rej_busy_slot", 32'(cap_err_o), 32'h1);
                done_i = 1; wr_slot_i = 1;
                tick();
                done_i = 0;
                check("stall2_data", st_data_o, 32'h105);
                check("cap_ok_other_slot", 32'(cap_err_o), 32'h0);
                check("cap_slot1_valid", 32'(slot_valid_o), 32'h6);
                tick();
                check("stall3_data", st_data_o, 32'h105);
                check("stall3_valid", 32'(st_valid_o), 32'h1);
                st_ready_i = 1;
            end
            check($sformatf("dump2_data_%0d", i), st_data_o, exp_beats[i]);
            check($sformatf("dump2_last_%0d", i), 32'(st_last_o), (i == 8) ? 32'h1 : 32'h0);
            tick();
        end
        check("dump2_busy_low", 32'(busy_o), 32'h0);

        // Slot 2 kept old data; slot 1 took new data
        rd_en_i = 1; rd_slot_i = 2; rd_elem_i = 5;
        tick();
        check("rd_2_5_unchanged", rd_data_o, 32'h105);
        rd_slot_i = 1; rd_elem_i = 5;
        tick();
        rd_en_i = 0;
        check("rd_1_5", rd_data_o, 32'h205);

        // Dump of invalid slot 3
        dump_start_i = 1; dump_slot_i = 3; dump_dim_i = 2;
        tick();
        dump_start_i = 0;
        check("dump_inv_err", 32'(cap_err_o), 32'h1);
        check("dump_inv_busy", 32'(busy_o), 32'h0);
        tick();
        check("dump_inv_err_pulse", 32'(cap_err_o), 32'h0);

        // Capture beats clear on the same slot; then clear alone
        clr_i = 1; clr_slot_i = 1; done_i = 1; wr_slot_i = 1;
        tick();
        done_i = 0;
        check("clr_cap_same", 32'(slot_valid_o), 32'h6);
        tick();
        clr_i = 0;
        check("clr_only", 32'(slot_valid_o), 32'h4);

        // dim 1: single beat flagged last
        dump_start_i = 1; dump_slot_i = 2; dump_dim_i = 1;
        tick();
        dump_start_i = 0;
        check("dim1_data", st_data_o, 32'h100);
        check("dim1_last", 32'(st_last_o), 32'h1);
        tick();
        check("dim1_busy_low", 32'(busy_o), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
